// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 register file with byte-lane writes, overflow write suppression and bookkeeping.
// Optional macro REGFILE_BYPASS_EN: a same-cycle write is forwarded (lane-merged) onto busA/busB.
module wb_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        overflow_f,
    input  logic [31:0] Dout_f,
    input  logic [31:0] result_f,
    input  logic [4:0]  Rw_f,
    input  logic        RegWr_f,
    input  logic        RegWr_4f,
    input  logic        RegWr_3f,
    input  logic        RegWr_2f,
    input  logic        RegWr_1f,
    input  logic        MemtoReg_f,
    input  logic        OvSel_f,
    input  logic [4:0]  Ra,
    input  logic [4:0]  Rb,
    output logic [31:0] busA,
    output logic [31:0] busB,
    output logic [31:0] wb_data,
    output logic        wb_we,
    output logic        ov_trap,
    output logic        ov_sticky,
    output logic [7:0]  ov_count
);

    logic [31:0] r_regs [0:31];
    logic        r_ov_trap;
    logic        r_ov_sticky;
    logic [7:0]  r_ov_count;

    logic [3:0]  w_lanes;
    logic [31:0] w_mask;
    logic        w_kill;
    logic        w_event;
    logic [31:0] w_stored_a;
    logic [31:0] w_stored_b;

    assign w_lanes = {RegWr_4f, RegWr_3f, RegWr_2f, RegWr_1f};
    assign w_mask  = {{8{w_lanes[3]}}, {8{w_lanes[2]}}, {8{w_lanes[1]}}, {8{w_lanes[0]}}};
    assign w_kill  = OvSel_f & overflow_f;
    // An overflow event ignores destination and lanes: any trapping write request counts.
    assign w_event = RegWr_f & w_kill;

    assign wb_data = MemtoReg_f ? Dout_f : result_f;
    assign wb_we   = RegWr_f & ~w_kill & (Rw_f != 5'd0) & (|w_lanes);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
            r_ov_trap   <= 1'b0;
            r_ov_sticky <= 1'b0;
            r_ov_count  <= 8'd0;
        end else begin
            if (wb_we) begin
                r_regs[Rw_f] <= (r_regs[Rw_f] & ~w_mask) | (wb_data & w_mask);
            end
            r_ov_trap <= w_event;
            if (w_event) begin
                r_ov_sticky <= 1'b1;
                if (r_ov_count != 8'hFF) begin
                    r_ov_count <= r_ov_count + 8'd1;
                end
            end
        end
    end

    assign w_stored_a = (Ra == 5'd0) ? 32'd0 : r_regs[Ra];
    assign w_stored_b = (Rb == 5'd0) ? 32'd0 : r_regs[Rb];

`ifdef REGFILE_BYPASS_EN
    // wb_we already excludes register 0, so a match never forwards into r0.
    assign busA = (wb_we && (Ra == Rw_f)) ? ((w_stored_a & ~w_mask) | (wb_data & w_mask)) : w_stored_a;
    assign busB = (wb_we && (Rb == Rw_f)) ? ((w_stored_b & ~w_mask) | (wb_data & w_mask)) : w_stored_b;
`else
    assign busA = w_stored_a;
    assign busB = w_stored_b;
`endif

    assign ov_trap   = r_ov_trap;
    assign ov_sticky = r_ov_sticky;
    assign ov_count  = r_ov_count;

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and general-purpose register file of the pipelined CPU. Consumes the registered MEM/WB bundle, selects memory load data or the ALU result, and applies byte-lane writes into a 32×32 register file. Suppresses writes on trapping arithmetic overflow and keeps overflow bookkeeping. Serves the two combinational read ports used by ID.

## Interface
Parameters:
- none (32 registers × 32 bits fixed)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- overflow_f  in  1  ALU overflow for the instruction in WB
- Dout_f  in  32  load data from data memory
- result_f  in  32  ALU result
- Rw_f  in  5  destination register number
- RegWr_f  in  1  register write request
- RegWr_4f, RegWr_3f, RegWr_2f, RegWr_1f  in  1 each  byte-lane enables for bits [31:24], [23:16], [15:8], [7:0]
- MemtoReg_f  in  1  1 = write Dout_f, 0 = write result_f
- OvSel_f  in  1  1 = instruction traps on overflow (add/sub/addi)
- Ra, Rb  in  5  read register numbers
- busA, busB  out  32  read data
- wb_data  out  32  selected write-back data, for EX forwarding
- wb_we  out  1  effective write this cycle, for EX forwarding
- ov_trap  out  1  one-cycle pulse: a write was suppressed by overflow
- ov_sticky  out  1  set on any suppressed write; cleared only by reset
- ov_count  out  8  count of suppressed writes, saturating

## Operation
- wb_data = MemtoReg_f ? Dout_f : result_f (combinational).
- kill = OvSel_f & overflow_f.
- wb_we = RegWr_f & ~kill & (Rw_f != 0) & (any lane enable set) (combinational).
- On clock edge with rst_n=1 and wb_we=1, for each lane k with enable set, reg[Rw_f] lane k takes wb_data lane k. Other lanes are unchanged.
- Full-word writes assert all four lane enables. RegWr_f=1 with no lanes enabled changes nothing.
- Register 0 reads as 0 always. Writes to register 0 are discarded and give wb_we=0.
- Overflow event = RegWr_f & kill, regardless of Rw_f or the lane enables. On an event:
  - ov_trap=1 in the next cycle
  - ov_sticky set
  - ov_count increments, holding at 255
- kill without RegWr_f (for example a branch) is not an event.
- Reads: busA = reg[Ra], busB = reg[Rb]. Both are combinational and independent; Ra == Rb is legal.

## Timing
- Reset, on a rising edge with rst_n=0:
  - all 32 registers become 0
  - ov_trap=0, ov_sticky=0, ov_count=0
  - Reset has priority over a concurrent write or overflow event, so the write is lost.
- Write latency: the value is stored on the edge that ends the WB cycle. Read ports show it from the next cycle, unless bypass is enabled (see Configuration).
- ov_trap: registered; high for exactly one cycle per event. Back-to-back events keep it high on consecutive cycles, and ov_count increments on each.
- ov_count at 255: further events still pulse ov_trap; the count stays at 255.
- wb_data and wb_we follow their inputs in the same cycle, with no register stage.
- Reset released mid-stream: the first edge with rst_n=1 performs a normal write from the current inputs.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If wb_we=1 and Ra == Rw_f, busA returns the lane-merged value: new bytes in enabled lanes, stored bytes elsewhere.
  - busB does the same for Rb.
  - A write is visible on the read ports in the same cycle, so ID needs no extra forwarding from WB.
- Not defined:
  - busA/busB always return stored contents; a same-cycle write is seen the following cycle.
  - The ID/EX hazard logic must then handle the WB-to-ID distance.

## Test plan
- Reset: hold rst_n=0 for 1 cycle after writing reg 5 = 0x12345678 → Ra=5 gives busA=0; ov_sticky=0, ov_count=0.
- Full-word and byte writes: RegWr_f=1, all lanes, Rw_f=3, MemtoReg_f=0, result_f=0xAABBCCDD. Then RegWr_1f only, MemtoReg_f=1, Dout_f=0x00000011 → reg 3 = 0xAABBCC11.
- Register 0: full write of 0xFFFFFFFF to Rw_f=0 → wb_we=0 and busA with Ra=0 reads 0.
- Overflow: RegWr_f=1, OvSel_f=1, overflow_f=1, Rw_f=7, result_f=0x80000000 → reg 7 unchanged; ov_trap high one cycle later for one cycle; ov_count=1; ov_sticky=1. The same inputs with OvSel_f=0 write 0x80000000.
- Saturation: 300 consecutive overflow events → ov_trap high for 300 cycles; ov_count stops at 255.
- Bypass: write 0x0000BEEF to reg 9 with Ra=9 in the same cycle → busA=0x0000BEEF that cycle if REGFILE_BYPASS_EN is defined, the old value if not. In both builds busA=0x0000BEEF the next cycle.
